// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Render-domain frame sequencer sitting between the VGA timing generator and
// the render pipeline (frame_driver, render_manager, double_framebuffer).
// It synchronises the pixel-domain frame pulse, waits until the current frame
// has been fully fed and rendered, then issues one framebuffer swap followed
// by one begin_frame per displayed frame. Frames whose render overruns a
// display frame are counted as drops; a hung render is released by a
// watchdog.
//
// Parameters
//   SYNC_STAGES     synchroniser depth on frame_async (values below 2 use 2)
//   TIMEOUT_CYCLES  clk_render cycles allowed in RENDER before forced completion
//   CNT_W           width of frame_count / drop_count
//
// Ports
//   clk_render     in   render clock
//   rst_n          in   asynchronous active-low reset
//   frame_async    in   frame-start pulse from pixel domain (>= 2 clk_render high)
//   create_done    in   scene loaded (level); low forces IDLE
//   feed_done      in   one-cycle pulse: all triangles issued for this frame
//   renderer_busy  in   render_manager busy (level)
//   clear_stats    in   synchronous clear of frame_count, drop_count, timeout_flag
//   swap           out  one-cycle framebuffer swap strobe
//   begin_frame    out  one-cycle render start strobe
//   rendering      out  high while the FSM is in RENDER
//   frame_count    out  number of begin_frame strobes, wraps
//   drop_count     out  number of overrun frames, saturates at all-ones
//   timeout_flag   out  sticky watchdog indication
//   state_dbg      out  current FSM state encoding (observation only)
//
// Handshake: swap and begin_frame are fire-and-forget strobes. Each is high
// for exactly one clk_render cycle, there is no ready/back-pressure, and the
// two are never high in the same cycle. The consumer must act on the cycle
// the strobe is seen.
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic             clk_render,
    input  logic             rst_n,
    input  logic             frame_async,
    input  logic             create_done,
    input  logic             feed_done,
    input  logic             renderer_busy,
    input  logic             clear_stats,
    output logic             swap,
    output logic             begin_frame,
    output logic             rendering,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             timeout_flag,
    output logic [2:0]       state_dbg
);

    // Fewer than two stages would not be a metastability-safe synchroniser.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        SWAP   = 3'd2,
        START  = 3'd3,
        RENDER = 3'd4,
        READY  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_N-1:0] sync_q;
    logic              sync_d;
    logic              frame_edge;

    logic              done_latch;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;
    logic              render_done;

    // -------------------------------------------------------------------------
    // frame_async synchroniser plus one delay flop for rising-edge detection.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_render or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], frame_async};
            sync_d <= sync_q[SYNC_N-1];
        end
    end

    assign frame_edge = sync_q[SYNC_N-1] & ~sync_d;

    // feed_done is accepted in the same cycle it arrives so a frame whose
    // renderer is already idle does not lose a cycle waiting for the latch.
    assign render_done = (done_latch | feed_done) & ~renderer_busy;
    assign wd_expired  = (wd_cnt == WD_LAST);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_render or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (create_done) state_next = ARMED;
            end
            // No completed frame exists yet, so the first edge starts a
            // render directly without a swap.
            ARMED: begin
                if (frame_edge) state_next = START;
            end
            SWAP: begin
                state_next = START;
            end
            START: begin
                state_next = RENDER;
            end
            // An edge arriving here is an overrun: the display keeps the old
            // buffer and the swap waits for the next edge seen in READY.
            RENDER: begin
                if (render_done || wd_expired) state_next = READY;
            end
            READY: begin
                if (frame_edge) state_next = SWAP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Losing the scene overrides everything; no pending strobe is issued
        // because strobes are decoded from state_next.
        if (!create_done) state_next = IDLE;
    end

    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Registered strobes, decoded from the next state so they are high for
    // exactly the cycle the FSM spends in SWAP / START.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_render or negedge rst_n) begin
        if (!rst_n) begin
            swap        <= 1'b0;
            begin_frame <= 1'b0;
            rendering   <= 1'b0;
        end else begin
            swap        <= (state_next == SWAP);
            begin_frame <= (state_next == START);
            rendering   <= (state_next == RENDER);
        end
    end

    // -------------------------------------------------------------------------
    // Done latch and watchdog. Both only live while rendering; every other
    // state (START included, and the forced return to IDLE) clears them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_render or negedge rst_n) begin
        if (!rst_n) begin
            done_latch <= 1'b0;
            wd_cnt     <= '0;
        end else if (state == RENDER && create_done) begin
            if (feed_done) done_latch <= 1'b1;
            // Hold at the terminal value; the FSM leaves RENDER on that cycle.
            if (!wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            done_latch <= 1'b0;
            wd_cnt     <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics. clear_stats takes priority over any coincident increment.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_render or negedge rst_n) begin
        if (!rst_n) begin
            frame_count  <= '0;
            drop_count   <= '0;
            timeout_flag <= 1'b0;
        end else if (clear_stats) begin
            frame_count  <= '0;
            drop_count   <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state_next == START) begin
                frame_count <= frame_count + CNT_W'(1);
            end
            if (state == RENDER && frame_edge && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (state == RENDER && wd_expired) begin
                timeout_flag <= 1'b1;
            end
        end
    end

endmodule
